// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared constants for the IF/DM memory arbiter:
//   - FSM state encodings (IDLE, BUSY_IF, BUSY_DM, DONE)
//   - grant encodings (GRANT_IF, GRANT_DM)
//   - ABORT_DATA: all-ones word returned by a read that timed out
//     (wide enough for any DATA_W up to 64)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t BUSY_IF = 2'd1;
    localparam state_t BUSY_DM = 2'd2;
    localparam state_t DONE    = 2'd3;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    localparam logic [63:0] ABORT_DATA = '1;

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the fetch requester, data requester and memory-port signals of the
// arbiter. Port names keep their direction suffix as seen from the arbiter.
//   slave  : arbiter view (requester/memory inputs in, acks/data/mem_* out)
//   master : environment view (pipeline stages plus memory)
//
// Handshakes:
//   if_req_i / dm_req_i are held high until the matching one-cycle ack; the
//   requester may change or drop its request at the edge that ends the ack.
//   mem_req_o is held with stable address/we/wdata until the one-cycle
//   mem_ack_i; mem_rdata_i is valid only in the mem_ack_i cycle.
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ack_o;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_stall_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_ack_o;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_stall_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ack_i;

    logic              err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_ack_o, if_rdata_o, if_stall_o,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output dm_ack_o, dm_rdata_o, dm_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i, mem_ack_i,
        output err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_ack_o, if_rdata_o, if_stall_o,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  dm_ack_o, dm_rdata_o, dm_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i, mem_ack_i,
        input  err_o
    );

endinterface

// File: rtl/mem_arb_timer.sv
// -----------------------------------------------------------------------------
// mem_arb_timer
// Busy-cycle counter for the memory transaction timeout.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : restart the count (asserted on each grant)
//   enable_i     : count this cycle (asserted in every busy cycle)
//   timeout_o    : high in the TIMEOUT_CYCLES-th consecutive busy cycle
// -----------------------------------------------------------------------------
module mem_arb_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic timeout_o
);
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    // The count equals the number of busy cycles already completed, so the
    // pulse lands in the TIMEOUT_CYCLES-th busy cycle.
    assign timeout_o = enable_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i && !timeout_o) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port word memory between the IF-stage fetch requester and
// the MEM-stage data requester, one transaction at a time, round-robin on
// ties (data wins the first tie after reset).
//
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : mem_arbiter_if.slave (requesters, memory port, err_o)
//   state_o      : current FSM state (mem_arb_pkg encoding), for debug
//
// Build option:
//   MEM_ARB_TIMEOUT_EN - when defined, a busy transaction that sees no
//   mem_ack_i for TIMEOUT_CYCLES cycles is abandoned: the requester is acked
//   (reads return all-ones) and err_o is set until reset. When undefined the
//   arbiter waits indefinitely and err_o is 0.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.slave  bus,
    output state_t        state_o
);
    // Memory is word addressed; the byte offset is always dropped.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t            state_q;
    logic              last_grant_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;

    logic any_req;
    logic pick_dm;
    logic busy;
    logic abort;

    // Data is picked when it is the only requester, or when both request and
    // fetch was served last.
    always_comb begin
        any_req = bus.if_req_i | bus.dm_req_i;
        pick_dm = bus.dm_req_i & (~bus.if_req_i | (last_grant_q == GRANT_IF));
        busy    = (state_q == BUSY_IF) || (state_q == BUSY_DM);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    logic timeout;
    logic err_q;

    mem_arb_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   ((state_q == IDLE) && any_req),
        .enable_i  (busy),
        .timeout_o (timeout)
    );

    // A real ack in the same cycle as the timeout wins.
    assign abort = busy && !bus.mem_ack_i && timeout;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_o = err_q;
`else
    assign abort     = 1'b0;
    assign bus.err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_IF;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_ack_q     <= 1'b0;
            dm_ack_q     <= 1'b0;
            if_rdata_q   <= '0;
            dm_rdata_q   <= '0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        mem_req_q <= 1'b1;
                        if (pick_dm) begin
                            last_grant_q <= GRANT_DM;
                            mem_addr_q   <= bus.dm_addr_i & WORD_MASK;
                            mem_we_q     <= bus.dm_we_i;
                            mem_wdata_q  <= bus.dm_wdata_i;
                            state_q      <= BUSY_DM;
                        end else begin
                            last_grant_q <= GRANT_IF;
                            mem_addr_q   <= bus.if_addr_i & WORD_MASK;
                            mem_we_q     <= 1'b0;
                            state_q      <= BUSY_IF;
                        end
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    // The ack is raised on entry to DONE so that it is high
                    // for exactly the DONE cycle, alongside the new rdata.
                    if (bus.mem_ack_i || abort) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        state_q   <= DONE;
                        if (state_q == BUSY_IF) begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= bus.mem_ack_i ? bus.mem_rdata_i
                                                        : ABORT_DATA[DATA_W-1:0];
                        end else begin
                            dm_ack_q <= 1'b1;
                            if (!mem_we_q) begin
                                dm_rdata_q <= bus.mem_ack_i ? bus.mem_rdata_i
                                                            : ABORT_DATA[DATA_W-1:0];
                            end
                        end
                    end
                end
                // One dead cycle lets the requester retire its request
                // before arbitration looks at it again.
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.dm_ack_o    = dm_ack_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.if_stall_o  = bus.if_req_i & ~if_ack_q;
    assign bus.dm_stall_o  = bus.dm_req_i & ~dm_ack_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: requester driver tasks, a memory responder
// with configurable wait states, a transaction-level model with an expected
// queue checked every cycle on the falling edge, and literal expectations for
// latency, ordering and reset behaviour. Timeout tests run when
// MEM_ARB_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int TMO    = 8;
    localparam int EW     = 66;
    localparam int BUDGET = 200;
    localparam logic WHO_IF = 1'b0;
    localparam logic WHO_DM = 1'b1;

    // ---------------- clock / reset ----------------
    logic   clk_i = 1'b0;
    logic   rst_i = 1'b1;
    state_t state_o;

    always #5 clk_i = ~clk_i;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    // {who, we, word address, wdata}
    logic [EW-1:0] exp_q[$];

    logic [31:0] mem_model [logic [31:0]];

    logic        chk_en = 1'b0;
    logic [31:0] m_if_rdata, m_dm_rdata;
    logic        m_err;
    logic        due, due_who, due_we;
    logic [31:0] due_data;
    logic        txn_active;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata, last_addr;
    int          busy_len, req_cycles, we_cycles, txn_count;

    int  mem_delay = 0;
    bit  no_ack    = 1'b0;
    bit  stray_ack = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void expect_txn(input logic who, input logic we,
                                       input logic [31:0] a, input logic [31:0] wd);
        exp_q.push_back({who, we, a & ~32'h3, wd});
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // ---------------- memory responder ----------------
    int wait_cnt  = 0;
    bit resp_done = 1'b0;

    always @(posedge clk_i) begin
        #1;
        if (stray_ack) begin
            bus.mem_ack_i   = 1'b1;
            bus.mem_rdata_i = 32'h5555_AAAA;
            stray_ack       = 1'b0;
        end else if (bus.mem_req_o && !resp_done && !no_ack && !rst_i) begin
            if (wait_cnt == mem_delay) begin
                bus.mem_ack_i = 1'b1;
                if (bus.mem_we_o) begin
                    mem_model[bus.mem_addr_o] = bus.mem_wdata_o;
                    bus.mem_rdata_i = ~bus.mem_addr_o;
                end else begin
                    bus.mem_rdata_i = mem_rd(bus.mem_addr_o);
                end
                resp_done = 1'b1;
            end else begin
                bus.mem_ack_i = 1'b0;
                wait_cnt++;
            end
        end else begin
            bus.mem_ack_i = 1'b0;
            if (!bus.mem_req_o) begin
                wait_cnt  = 0;
                resp_done = 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk_i) begin
        logic [EW-1:0] e;
        if (rst_i) begin
            m_if_rdata = '0;
            m_dm_rdata = '0;
            m_err      = 1'b0;
            due        = 1'b0;
            txn_active = 1'b0;
            busy_len   = 0;
        end else if (chk_en) begin
            // A completion seen last cycle must show up as exactly one ack now.
            chk("if_ack", bus.if_ack_o, due && (due_who == WHO_IF));
            chk("dm_ack", bus.dm_ack_o, due && (due_who == WHO_DM));
            if (due) begin
                if (due_who == WHO_IF) m_if_rdata = due_data;
                else if (!due_we)      m_dm_rdata = due_data;
                due = 1'b0;
            end
            chk("if_rdata", bus.if_rdata_o, m_if_rdata);
            chk("dm_rdata", bus.dm_rdata_o, m_dm_rdata);
            chk("if_stall", bus.if_stall_o, bus.if_req_i & ~bus.if_ack_o);
            chk("dm_stall", bus.dm_stall_o, bus.dm_req_i & ~bus.dm_ack_o);
            chk("err", bus.err_o, m_err);

            if (bus.mem_req_o) begin
                if (!txn_active) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_txn", 1'b1, 1'b0);
                        e = '0;
                    end else begin
                        e = exp_q.pop_front();
                        chk("mem_addr", bus.mem_addr_o, e[63:32]);
                        chk("mem_we", bus.mem_we_o, e[64]);
                        if (e[64]) chk("mem_wdata", bus.mem_wdata_o, e[31:0]);
                    end
                    due_who    = e[65];
                    due_we     = e[64];
                    lat_addr   = bus.mem_addr_o;
                    lat_we     = bus.mem_we_o;
                    lat_wdata  = bus.mem_wdata_o;
                    last_addr  = bus.mem_addr_o;
                    txn_count++;
                    txn_active = 1'b1;
                    busy_len   = 0;
                end else begin
                    chk("addr_stable", bus.mem_addr_o, lat_addr);
                    chk("we_stable", bus.mem_we_o, lat_we);
                    chk("wdata_stable", bus.mem_wdata_o, lat_wdata);
                end
                busy_len++;
                req_cycles++;
                if (bus.mem_we_o) we_cycles++;
                if (bus.mem_ack_i) begin
                    due        = 1'b1;
                    due_data   = bus.mem_rdata_i;
                    txn_active = 1'b0;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (busy_len == TMO) begin
                    due        = 1'b1;
                    due_data   = 32'hFFFF_FFFF;
                    m_err      = 1'b1;
                    txn_active = 1'b0;
                end
`endif
            end else begin
                if (txn_active) chk("req_dropped_early", 1'b1, 1'b0);
                txn_active = 1'b0;
                chk("mem_we_idle", bus.mem_we_o, 1'b0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] a, output int n, output int st);
        @(posedge clk_i); #1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = a;
        n  = 0;
        st = 0;
        do begin
            @(negedge clk_i);
            n++;
            if (bus.if_stall_o) st++;
        end while (!bus.if_ack_o && n < BUDGET);
        chk("if_ack_seen", bus.if_ack_o, 1'b1);
        @(posedge clk_i); #1;
        bus.if_req_i = 1'b0;
    endtask

    task automatic dm_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int n);
        @(posedge clk_i); #1;
        bus.dm_req_i   = 1'b1;
        bus.dm_we_i    = we;
        bus.dm_addr_i  = a;
        bus.dm_wdata_i = wd;
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!bus.dm_ack_o && n < BUDGET);
        chk("dm_ack_seen", bus.dm_ack_o, 1'b1);
        @(posedge clk_i); #1;
        bus.dm_req_i = 1'b0;
        bus.dm_we_i  = 1'b0;
    endtask

    // Request held across several fetches; the address moves on at the edge
    // that ends each ack.
    task automatic if_seq(input logic [31:0] a [3]);
        int n;
        @(posedge clk_i); #1;
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = a[0];
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                @(negedge clk_i);
                n++;
            end while (!bus.if_ack_o && n < BUDGET);
            chk("seq_ack_seen", bus.if_ack_o, 1'b1);
            @(posedge clk_i); #1;
            if (i < 2) bus.if_addr_i = a[i + 1];
            else       bus.if_req_i  = 1'b0;
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int n, n2, st, base;
        logic [31:0] seq_a [3];

        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.dm_req_i    = 1'b0;
        bus.dm_we_i     = 1'b0;
        bus.dm_addr_i   = '0;
        bus.dm_wdata_i  = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
        txn_count  = 0;
        req_cycles = 0;
        we_cycles  = 0;

        mem_model[32'h40]  = 32'h8C22_0004;
        mem_model[32'h20]  = 32'h0BAD_F00D;
        mem_model[32'h200] = 32'h1111_2222;
        mem_model[32'h100] = 32'h3333_4444;
        mem_model[32'h400] = 32'hA000_0400;
        mem_model[32'h404] = 32'hA000_0404;
        mem_model[32'h408] = 32'hA000_0408;

        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mem_req", bus.mem_req_o, 1'b0);
        chk("rst_mem_we", bus.mem_we_o, 1'b0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_if_ack", bus.if_ack_o, 1'b0);
        chk("rst_dm_ack", bus.dm_ack_o, 1'b0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
        chk("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_state", state_o, IDLE);
        chk_en = 1'b1;

        // IF read, zero wait states: ack in cycle 2, stall for cycles 0-1.
        mem_delay = 0;
        expect_txn(WHO_IF, 1'b0, 32'h40, 32'h0);
        if_txn(32'h40, n, st);
        chk("if_latency", n, 3);
        chk("if_stall_cycles", st, 2);
        chk("if_rdata_lit", bus.if_rdata_o, 32'h8C22_0004);

        // DM read to give dm_rdata a known value, then an unaligned write
        // with two extra wait states.
        expect_txn(WHO_DM, 1'b0, 32'h20, 32'h0);
        dm_txn(1'b0, 32'h20, 32'h0, n);
        chk("dm_rd_rdata", bus.dm_rdata_o, 32'h0BAD_F00D);
        req_cycles = 0;
        we_cycles  = 0;
        mem_delay  = 2;
        expect_txn(WHO_DM, 1'b1, 32'h13, 32'hDEAD_BEEF);
        dm_txn(1'b1, 32'h13, 32'hDEAD_BEEF, n);
        chk("wr_latency", n, 5);
        chk("wr_mem_addr", last_addr, 32'h10);
        chk("wr_we_cycles", we_cycles, 3);
        chk("wr_req_cycles", req_cycles, 3);
        chk("wr_rdata_held", bus.dm_rdata_o, 32'h0BAD_F00D);
        chk("wr_mem_word", mem_rd(32'h10), 32'hDEAD_BEEF);

        // Tie straight after reset: data first, fetch after the dead cycle.
        do_reset();
        mem_delay = 0;
        expect_txn(WHO_DM, 1'b0, 32'h200, 32'h0);
        expect_txn(WHO_IF, 1'b0, 32'h100, 32'h0);
        fork
            if_txn(32'h100, n, st);
            dm_txn(1'b0, 32'h200, 32'h0, n2);
        join
        chk("tie1_dm_latency", n2, 3);
        chk("tie1_if_latency", n, 6);
        chk("tie1_if_rdata", bus.if_rdata_o, 32'h3333_4444);
        chk("tie1_dm_rdata", bus.dm_rdata_o, 32'h1111_2222);

        // Data served last, so the next tie goes to fetch.
        expect_txn(WHO_DM, 1'b0, 32'h204, 32'h0);
        dm_txn(1'b0, 32'h204, 32'h0, n2);
        expect_txn(WHO_IF, 1'b0, 32'h108, 32'h0);
        expect_txn(WHO_DM, 1'b0, 32'h208, 32'h0);
        fork
            if_txn(32'h108, n, st);
            dm_txn(1'b0, 32'h208, 32'h0, n2);
        join
        chk("tie2_if_latency", n, 3);
        chk("tie2_dm_latency", n2, 6);

        // Reset in the middle of a data read, then a stray memory ack.
        no_ack = 1'b1;
        expect_txn(WHO_DM, 1'b0, 32'h300, 32'h0);
        @(posedge clk_i); #1;
        bus.dm_req_i  = 1'b1;
        bus.dm_we_i   = 1'b0;
        bus.dm_addr_i = 32'h300;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("busy_state", state_o, BUSY_DM);
        chk("busy_req", bus.mem_req_o, 1'b1);
        @(posedge clk_i); #1;
        rst_i        = 1'b1;
        bus.dm_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i  = 1'b0;
        no_ack = 1'b0;
        @(negedge clk_i);
        chk("rstbusy_req", bus.mem_req_o, 1'b0);
        chk("rstbusy_state", state_o, IDLE);
        chk("rstbusy_dm_ack", bus.dm_ack_o, 1'b0);
        stray_ack = 1'b1;
        @(negedge clk_i);
        chk("stray_ack_seen", bus.mem_ack_i, 1'b1);
        chk("stray_state", state_o, IDLE);
        @(negedge clk_i);
        chk("stray_dm_ack", bus.dm_ack_o, 1'b0);
        chk("stray_state2", state_o, IDLE);
        chk("stray_req", bus.mem_req_o, 1'b0);

        // Back-to-back fetches, address moved at each ack edge.
        mem_delay = 1;
        base = txn_count;
        seq_a[0] = 32'h400;
        seq_a[1] = 32'h404;
        seq_a[2] = 32'h408;
        for (int i = 0; i < 3; i++) expect_txn(WHO_IF, 1'b0, seq_a[i], 32'h0);
        if_seq(seq_a);
        repeat (3) @(negedge clk_i);
        chk("seq_txn_count", txn_count - base, 3);
        chk("seq_last_rdata", bus.if_rdata_o, 32'hA000_0408);

`ifdef MEM_ARB_TIMEOUT_EN
        // Memory never answers: abandoned after TMO busy cycles.
        no_ack     = 1'b1;
        req_cycles = 0;
        expect_txn(WHO_IF, 1'b0, 32'h500, 32'h0);
        if_txn(32'h500, n, st);
        chk("tmo_latency", n, TMO + 2);
        chk("tmo_req_cycles", req_cycles, TMO);
        chk("tmo_rdata", bus.if_rdata_o, 32'hFFFF_FFFF);
        chk("tmo_err", bus.err_o, 1'b1);
        no_ack = 1'b0;
        expect_txn(WHO_DM, 1'b0, 32'h20, 32'h0);
        dm_txn(1'b0, 32'h20, 32'h0, n2);
        chk("tmo_err_sticky", bus.err_o, 1'b1);
        do_reset();
        @(negedge clk_i);
        chk("tmo_err_cleared", bus.err_o, 1'b0);
`endif

        repeat (4) @(negedge clk_i);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one word-wide, single-port memory between the instruction-fetch requester (IF stage) and the data-access requester (MEM stage) of the 5-stage pipeline.
- Sequences one transaction at a time over a req/ack memory handshake.
- Returns read data to the requester and produces the stall signals the pipeline uses to freeze PC, IF_ID and the later stage registers.

Parameters:
ADDR_W, 32, address width of requesters and memory port
DATA_W, 32, data word width
TIMEOUT_CYCLES, 255, maximum cycles to wait for mem_ack_i (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
if_req_i  in  1  fetch request, held until if_ack_o
if_addr_i  in  ADDR_W  fetch address
if_ack_o  out  1  one-cycle pulse: fetch complete, if_rdata_o valid
if_rdata_o  out  DATA_W  fetched instruction
if_stall_o  out  1  if_req_i & ~if_ack_o
dm_req_i  in  1  data request, held until dm_ack_o
dm_we_i  in  1  1 = write, 0 = read
dm_addr_i  in  ADDR_W  data address
dm_wdata_i  in  DATA_W  write data
dm_ack_o  out  1  one-cycle pulse: data access complete
dm_rdata_o  out  DATA_W  read data
dm_stall_o  out  1  dm_req_i & ~dm_ack_o
mem_req_o  out  1  memory request, held until mem_ack_i
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  memory address; bits [1:0] forced to 0
mem_wdata_o  out  DATA_W  memory write data
mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
mem_ack_i  in  1  one-cycle completion pulse from memory
err_o  out  1  sticky timeout flag (0 without the optional feature)

Behaviour:
- Reset: state=IDLE. last_grant=IF, so data wins the first tie.
  - Outputs after reset: mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, if_ack_o=0, dm_ack_o=0, if_rdata_o=0, dm_rdata_o=0, err_o=0.
- States: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE, when a request is pending:
  - Only one request pending: grant it.
  - Both pending: grant the requester that is not last_grant (round-robin).
  - On grant: register addr, we, wdata (wdata only for DM) onto the mem_* outputs, set mem_req_o=1, set last_grant, and move to BUSY_IF or BUSY_DM.
  - No request pending: stay in IDLE.
- BUSY_x:
  - mem_req_o, mem_addr_o, mem_we_o and mem_wdata_o stay stable.
  - mem_ack_i is accepted in any cycle, including the first cycle mem_req_o is high.
  - On mem_ack_i: capture mem_rdata_i into the granted rdata register (DM writes leave dm_rdata_o unchanged), clear mem_req_o and mem_we_o, and go to DONE.
- DONE:
  - Pulse the granted ack for exactly one cycle, then go to IDLE.
  - The requester changes or drops its request at that edge.
  - IDLE re-arbitrates on the following cycle, so a completed request is never serviced twice.
- Latency: request seen in cycle 0, mem_req_o high in cycle 1. With mem_ack_i in cycle 1, the ack pulses in cycle 2. Minimum stall is 2 cycles; each extra memory wait cycle adds 1.
- Stall outputs are combinational from the request and ack signals. All other outputs are registered.
- rdata outputs hold their value until the next completion for the same requester.
- mem_ack_i arriving in IDLE or DONE is ignored.
- Requester request changes while it is not granted are tolerated; the latched address is what gets used.
- Reset while BUSY: the next edge returns to IDLE with mem_req_o=0 and no ack. A later stray mem_ack_i is ignored.
- A single transaction is never split and never preempted.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Enabled:
  - A counter clears on each grant and increments every BUSY cycle.
  - When it reaches TIMEOUT_CYCLES without mem_ack_i: clear mem_req_o, set err_o (sticky until rst_i), go to DONE and pulse the granted ack.
  - The rdata of an aborted read is forced to all-ones (0xFFFFFFFF at 32 bits), so the pipeline does not deadlock.
- Disabled: no counter; BUSY waits indefinitely; err_o is tied to 0.

Decomposition:
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY_IF, BUSY_DM, DONE);
  - grant encoding constants GRANT_IF and GRANT_DM;
  - the ABORT_DATA all-ones constant.
- Sub-module mem_arb_timer holds the timeout counter, is instantiated only under MEM_ARB_TIMEOUT_EN, and has inputs clear/enable and a timeout pulse output.

Test Plan:
- IF read only, addr 0x40, memory acks in the first mem_req_o cycle with 0x8C220004 -> if_ack_o in cycle 2, if_rdata_o=0x8C220004, if_stall_o high for exactly cycles 0-1.
- DM write, addr 0x13, data 0xDEADBEEF, memory acks after 3 cycles -> mem_addr_o=0x10, mem_we_o=1 for 3 cycles, dm_ack_o pulses once, dm_rdata_o unchanged.
- IF and DM requests both raised in the same cycle after reset -> DM granted first; IF granted in the IDLE cycle after dm_ack_o; next simultaneous tie goes to IF.
- rst_i asserted during BUSY_DM, then a stray mem_ack_i -> mem_req_o=0 on the next cycle, no dm_ack_o, state stays IDLE.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never acks an IF read -> mem_req_o drops after 8 busy cycles, if_ack_o pulses with if_rdata_o=0xFFFFFFFF, err_o stays 1 until reset.
- Back-to-back IF requests with the address changed at the edge of each ack -> each address appears on mem_addr_o exactly once, with no duplicate transactions.
